multdiv_unit: RTL

//  Iterative 32-bit signed multiply/divide unit in the execute stage.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_unit_div_step.sv | 23 ++
 rtl/multdiv_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
// MULTDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
package multdiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;
`ifdef MULTDIV_RADIX4_EN
   localparam int unsigned MUL_ITERS = 16;
`else
   localparam int unsigned MUL_ITERS = 32;
`endif
   localparam int unsigned DIV_ITERS = 32;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   // Magnitude of a two's complement value; -2^31 maps to 2^31 as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One non-restoring division iteration on unsigned magnitudes.
// The remainder carries two extra bits so it can swing in [-2D, 2D) before correction.
module div_step
   import multdiv_pkg::*;
(
   input  logic [WIDTH+1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH+1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] dvs;

   always_comb begin
      shifted = {rem_i[WIDTH:0], quo_i[WIDTH-1]};
      dvs     = {2'b00, div_i};
      rem_o   = rem_i[WIDTH+1] ? shifted + dvs : shifted - dvs;
      quo_o   = {quo_i[WIDTH-2:0], ~rem_o[WIDTH+1]};
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply (Booth) / divide (non-restoring) unit.
// MULTDIV_RADIX4_EN selects radix-4 Booth multiply; divide is unaffected.
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*WIDTH:0] acc_q, acc_d;
   logic [WIDTH+1:0] rem_q, rem_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             is_mul_q, is_mul_d;
   logic             exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;

   logic             start;
   logic [2*WIDTH:0] mul_next;
   logic [WIDTH+1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [2*WIDTH-1:0] prod;
   logic             mul_ovf;

   assign start = ctrl_MULT | ctrl_DIV;
   assign prod  = acc_q[2*WIDTH:1];
   assign mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

   // acc_q layout for multiply: {P, A, q-1}; sums are widened so M = -2^31 cannot overflow.
`ifdef MULTDIV_RADIX4_EN
   logic [WIDTH+1:0] p4, m4, pp4, sum4;
   always_comb begin
      p4 = {{2{acc_q[2*WIDTH]}}, acc_q[2*WIDTH:WIDTH+1]};
      m4 = {{2{opa_q[WIDTH-1]}}, opa_q};
      unique case (acc_q[2:0])
         3'b001, 3'b010: pp4 = m4;
         3'b011:         pp4 = m4 << 1;
         3'b100:         pp4 = -(m4 << 1);
         3'b101, 3'b110: pp4 = -m4;
         default:        pp4 = '0;
      endcase
      sum4     = p4 + pp4;
      mul_next = {sum4, acc_q[WIDTH:2]};
   end
`else
   logic [WIDTH:0] p2, m2, sum2;
   always_comb begin
      p2 = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
      m2 = {opa_q[WIDTH-1], opa_q};
      unique case (acc_q[1:0])
         2'b01:   sum2 = p2 + m2;
         2'b10:   sum2 = p2 - m2;
         default: sum2 = p2;
      endcase
      mul_next = {sum2, acc_q[WIDTH:1]};
   end
`endif

   div_step u_div_step (
      .rem_i (rem_q),
      .quo_i (acc_q[WIDTH-1:0]),
      .div_i (abs_val(opb_q)),
      .rem_o (rem_nxt),
      .quo_o (quo_nxt)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      is_mul_d = is_mul_q;
      res_d    = res_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      busy_d   = (state_q != IDLE);

      unique case (state_q)
         IDLE: ;
         MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = DONE;
         end
         DIV: begin
            acc_d[WIDTH-1:0] = quo_nxt;
            rem_d            = rem_nxt;
            cnt_d            = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            rdy_d   = 1'b1;
            if (is_mul_q) begin
               res_d = prod[WIDTH-1:0];
               exc_d = mul_ovf;
            end else if ((opb_q == '0) ||
                         (opa_q == {1'b1, {(WIDTH-1){1'b0}}} && opb_q == '1)) begin
               res_d = '0;
               exc_d = 1'b1;
            end else begin
               res_d = (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               exc_d = 1'b0;
            end
         end
      endcase

      // A new start always wins, including on the finishing edge: the old result is dropped.
      if (start) begin
         state_d  = ctrl_MULT ? MUL : DIV;
         is_mul_d = ctrl_MULT;
         cnt_d    = '0;
         opa_d    = data_operandA;
         opb_d    = data_operandB;
         acc_d    = ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB, 1'b0}
                              : {{(WIDTH+1){1'b0}}, abs_val(data_operandA)};
         rem_d    = '0;
         res_d    = '0;
         exc_d    = 1'b0;
         rdy_d    = 1'b0;
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         is_mul_q <= 1'b0;
         res_q    <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         is_mul_q <= is_mul_d;
         res_q    <= res_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule
